// File: rtl/riscv_pkg.sv
// Shared defaults and types for the register scoreboard.
package riscv_pkg;

    localparam int RF_ADDR_WIDTH_DEF = 5;
    localparam int CNT_WIDTH_DEF     = 2;

    typedef logic [RF_ADDR_WIDTH_DEF-1:0] rf_addr_t;
    typedef logic [CNT_WIDTH_DEF-1:0]     sb_cnt_t;

endpackage

// File: rtl/riscv_sb_counter.sv
// One in-flight write counter for a single architectural register.
module riscv_sb_counter
    import riscv_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic at_max,
    output logic underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt;

    // Overflow saturates silently; a release with nothing in flight is sticky-flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            underflow <= 1'b0;
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt == '0) begin
                underflow <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy   = (cnt != '0);
    assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/riscv_scoreboard.sv
// Long-latency producer scoreboard: tracks pending writes per register and
// raises the decode stall for RAW/WAW hazards or when any counter is full.
module riscv_scoreboard
    import riscv_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // issue_valid / wb_valid are one-cycle strobes with no ready: each
    // asserted cycle is exactly one event; stall_id is the only backpressure.
    input  logic                        issue_valid,
    input  logic [RF_ADDR_WIDTH-1:0]    issue_rd,
    input  logic                        wb_valid,
    input  logic [RF_ADDR_WIDTH-1:0]    wb_rd,
    input  logic [RF_ADDR_WIDTH-1:0]    rs1_id,
    input  logic [RF_ADDR_WIDTH-1:0]    rs2_id,
    input  logic [RF_ADDR_WIDTH-1:0]    rd_id,
    input  logic                        rs1_used_id,
    input  logic                        rs2_used_id,
    input  logic                        rd_write_id,
    output logic                        stall_id,
    output logic [2**RF_ADDR_WIDTH-1:0] busy_vec,
    output logic                        full,
    output logic                        err_underflow
);

    localparam int NUM_REGS = 2**RF_ADDR_WIDTH;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] at_max;
    logic [NUM_REGS-1:0] underflow;

    // x0 is never tracked, so its slot is tied off.
    assign busy[0]      = 1'b0;
    assign at_max[0]    = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic inc;
        logic dec;

        assign inc = issue_valid && (issue_rd == RF_ADDR_WIDTH'(r));
        assign dec = wb_valid && (wb_rd == RF_ADDR_WIDTH'(r));

        riscv_sb_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc),
            .dec       (dec),
            .busy      (busy[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    logic raw_rs1;
    logic raw_rs2;
    logic waw_rd;

    // Uses the registered state only, so a same-cycle writeback cannot release the stall.
    assign raw_rs1 = rs1_used_id && (rs1_id != '0) && busy[rs1_id];
    assign raw_rs2 = rs2_used_id && (rs2_id != '0) && busy[rs2_id];
    assign waw_rd  = rd_write_id && (rd_id != '0) && busy[rd_id];

    assign busy_vec      = busy;
    assign full          = |at_max;
    assign err_underflow = |underflow;
    assign stall_id      = raw_rs1 || raw_rs2 || waw_rd || full;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Directed bench for riscv_scoreboard with a count-based reference model.
module tb_riscv_scoreboard;

  localparam int AW      = 5;
  localparam int CW      = 2;
  localparam int NREG    = 2**AW;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int W       = NREG + 2;

  logic          clk;
  logic          rst_n;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [AW-1:0] rs1_id;
  logic [AW-1:0] rs2_id;
  logic [AW-1:0] rd_id;
  logic          rs1_used_id;
  logic          rs2_used_id;
  logic          rd_write_id;
  logic          stall_id;
  logic [NREG-1:0] busy_vec;
  logic          full;
  logic          err_underflow;

  int vectors;
  int miscompares;

  riscv_scoreboard #(
    .RF_ADDR_WIDTH (AW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rd_id         (rd_id),
    .rs1_used_id   (rs1_used_id),
    .rs2_used_id   (rs2_used_id),
    .rd_write_id   (rd_write_id),
    .stall_id      (stall_id),
    .busy_vec      (busy_vec),
    .full          (full),
    .err_underflow (err_underflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int        m_cnt [NREG];
  bit        m_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  bit        have_exp;

  function automatic logic [W-1:0] model_pack();
    logic [NREG-1:0] b;
    logic            f;
    b = '0;
    f = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      b[r] = (m_cnt[r] > 0);
      if (m_cnt[r] == CNT_MAX) f = 1'b1;
    end
    return {m_err, f, b};
  endfunction

  function automatic logic model_stall();
    logic f;
    f = 1'b0;
    for (int r = 1; r < NREG; r++) if (m_cnt[r] == CNT_MAX) f = 1'b1;
    if (rs1_used_id && rs1_id != 0 && m_cnt[rs1_id] > 0) return 1'b1;
    if (rs2_used_id && rs2_id != 0 && m_cnt[rs2_id] > 0) return 1'b1;
    if (rd_write_id && rd_id != 0 && m_cnt[rd_id] > 0) return 1'b1;
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_err = 1'b0;
      exp_q.delete();
      exp_q.push_back(model_pack());
    end else begin
      for (int r = 1; r < NREG; r++) begin
        bit inc;
        bit dec;
        inc = issue_valid && (int'(issue_rd) == r);
        dec = wb_valid && (int'(wb_rd) == r);
        if (inc && !dec) begin
          if (m_cnt[r] < CNT_MAX) m_cnt[r] = m_cnt[r] + 1;
        end else if (dec && !inc) begin
          if (m_cnt[r] == 0) m_err = 1'b1;
          else m_cnt[r] = m_cnt[r] - 1;
        end
      end
      exp_q.push_back(model_pack());
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic es;
    if (exp_q.size() > 0) begin
      cur_exp  = exp_q.pop_front();
      have_exp = 1'b1;
    end
    if (have_exp) begin
      vectors++;
      if ({err_underflow, full, busy_vec} !== cur_exp) begin
        miscompares++;
        $display("FAIL state @%0t: got err=%0b full=%0b busy=%h, want err=%0b full=%0b busy=%h",
                 $time, err_underflow, full, busy_vec, cur_exp[W-1], cur_exp[W-2], cur_exp[NREG-1:0]);
      end
      es = model_stall();
      vectors++;
      if (stall_id !== es) begin
        miscompares++;
        $display("FAIL stall_model @%0t: got %0b want %0b", $time, stall_id, es);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input int rd);
    issue_valid = v;
    issue_rd    = AW'(rd);
  endtask

  task automatic set_wb(input logic v, input int rd);
    wb_valid = v;
    wb_rd    = AW'(rd);
  endtask

  task automatic set_dec(input logic u1, input int r1, input logic u2, input int r2,
                         input logic wr, input int rd);
    rs1_used_id = u1;
    rs1_id      = AW'(r1);
    rs2_used_id = u2;
    rs2_id      = AW'(r2);
    rd_write_id = wr;
    rd_id       = AW'(rd);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    have_exp    = 1'b0;
    rst_n       = 1'b1;
    set_issue(1'b0, 0);
    set_wb(1'b0, 0);
    set_dec(1'b0, 0, 1'b0, 0, 1'b0, 0);
    #1 rst_n = 1'b0;
    step();
    step();
    check("reset_stall", 64'(stall_id), 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_busy", 64'(busy_vec), 64'd0);
    check("reset_err", 64'(err_underflow), 64'd0);
    check("reset_full", 64'(full), 64'd0);

    // RAW on x5: stall until the cycle after writeback
    set_issue(1'b1, 5);
    step();
    set_issue(1'b0, 0);
    set_dec(1'b1, 5, 1'b0, 0, 1'b0, 0);
    #1;
    check("raw_stall", 64'(stall_id), 64'd1);
    check("raw_busy5", 64'(busy_vec[5]), 64'd1);
    step();
    check("raw_hold", 64'(stall_id), 64'd1);
    set_wb(1'b1, 5);
    #1;
    check("raw_same_cycle_wb", 64'(stall_id), 64'd1);
    step();
    set_wb(1'b0, 0);
    #1;
    check("raw_release", 64'(stall_id), 64'd0);
    check("raw_busy5_clr", 64'(busy_vec[5]), 64'd0);
    set_dec(1'b0, 0, 1'b0, 0, 1'b0, 0);

    // register 0 is never tracked
    set_issue(1'b1, 0);
    step();
    set_issue(1'b0, 0);
    set_dec(1'b0, 0, 1'b1, 0, 1'b0, 0);
    #1;
    check("x0_stall", 64'(stall_id), 64'd0);
    check("x0_busy", 64'(busy_vec), 64'd0);
    set_dec(1'b0, 0, 1'b0, 0, 1'b0, 0);

    // simultaneous issue and writeback to x7
    set_issue(1'b1, 7);
    step();
    set_wb(1'b1, 7);
    step();
    set_issue(1'b0, 0);
    set_wb(1'b0, 0);
    #1;
    check("sim_busy7", 64'(busy_vec[7]), 64'd1);
    set_wb(1'b1, 7);
    step();
    set_wb(1'b0, 0);
    #1;
    check("sim_busy7_clr", 64'(busy_vec[7]), 64'd0);

    // two issues to x3, one writeback
    set_issue(1'b1, 3);
    step();
    step();
    set_issue(1'b0, 0);
    set_wb(1'b1, 3);
    step();
    set_wb(1'b0, 0);
    #1;
    check("x3_still_busy", 64'(busy_vec[3]), 64'd1);
    set_wb(1'b1, 3);
    step();
    set_wb(1'b0, 0);
    #1;
    check("x3_clr", 64'(busy_vec[3]), 64'd0);

    // saturation on x9 (fourth issue saturates silently) and WAW
    set_issue(1'b1, 9);
    repeat (4) step();
    set_issue(1'b0, 0);
    set_dec(1'b1, 1, 1'b0, 0, 1'b0, 0);
    #1;
    check("sat_full", 64'(full), 64'd1);
    check("sat_no_err", 64'(err_underflow), 64'd0);
    check("sat_unrelated_stall", 64'(stall_id), 64'd1);
    set_dec(1'b0, 0, 1'b0, 0, 1'b1, 9);
    set_wb(1'b1, 9);
    step();
    check("waw_full_drop", 64'(full), 64'd0);
    check("waw_stall_2", 64'(stall_id), 64'd1);
    step();
    check("waw_stall_1", 64'(stall_id), 64'd1);
    step();
    set_wb(1'b0, 0);
    #1;
    check("waw_release", 64'(stall_id), 64'd0);
    check("waw_busy9_clr", 64'(busy_vec[9]), 64'd0);
    set_dec(1'b0, 0, 1'b0, 0, 1'b0, 0);

    // writeback to x0 never flags; writeback to idle x12 does
    set_wb(1'b1, 0);
    step();
    set_wb(1'b0, 0);
    #1;
    check("wb_x0_no_err", 64'(err_underflow), 64'd0);
    set_wb(1'b1, 12);
    step();
    set_wb(1'b0, 0);
    #1;
    check("underflow_set", 64'(err_underflow), 64'd1);
    check("underflow_busy", 64'(busy_vec[12]), 64'd0);
    step();
    step();
    check("underflow_sticky", 64'(err_underflow), 64'd1);

    // asynchronous reset mid-stream
    set_issue(1'b1, 4);
    step();
    set_issue(1'b0, 0);
    set_dec(1'b1, 4, 1'b0, 0, 1'b0, 0);
    #1;
    check("pre_rst_busy4", 64'(busy_vec[4]), 64'd1);
    check("pre_rst_stall", 64'(stall_id), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy_vec), 64'd0);
    check("async_rst_err", 64'(err_underflow), 64'd0);
    check("async_rst_stall", 64'(stall_id), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    set_issue(1'b1, 4);
    step();
    set_issue(1'b0, 0);
    #1;
    check("post_rst_raw", 64'(stall_id), 64'd1);
    set_wb(1'b1, 4);
    step();
    set_wb(1'b0, 0);
    set_dec(1'b0, 0, 1'b0, 0, 1'b0, 0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
